avalon_bus_arbiter: RTL

Two-master, one-slave arbiter for the CPU's Avalon memory-mapped bus. Port 0 carries instruction fetches and port 1 carries data loads and stores; both share the single RAM slave. Transfers are forwarded with waitrequest handshaking, grants are held until the transfer completes, and fairness is round-robin. It sits between `top_level_cpu`'s internal fetch/data units and the RAM.

---
 rtl/avalon_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter
// Two-master, one-slave Avalon-MM arbiter. Port 0 carries instruction
// fetches, port 1 carries data loads and stores. Only the current owner's
// signals reach the slave, and ownership is held until that owner completes
// a transfer. Ties are broken round-robin using the last owner.
module avalon_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      state_reg;
    logic        last_owner_reg;
    logic [1:0]  grant_reg;

    logic [1:0]  port_read;
    logic [1:0]  port_write;
    logic [1:0]  req;
    logic [1:0]  port_wait;
    logic        sel;

    assign port_read  = {m1_read, m0_read};
    assign port_write = {m1_write, m0_write};

    // A port requests on read or write; only the owner sees the slave stall,
    // everyone else is held off.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req[gi]       = port_read[gi] | port_write[gi];
            assign port_wait[gi] = grant_reg[gi] ? waitrequest : 1'b1;
        end
    endgenerate

    assign m0_waitrequest = port_wait[0];
    assign m1_waitrequest = port_wait[1];

    // Read data is shared; a master may only sample it on its own completion.
    assign m0_readdata = readdata;
    assign m1_readdata = readdata;

    assign grant = grant_reg;
    assign busy  = |grant_reg;
    assign sel   = grant_reg[1];

    // Arbitration FSM: grant is registered alongside the state so that grant,
    // busy and the slave mux never depend combinationally on the requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_owner_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req[0] && (!req[1] || last_owner_reg)) begin
                        state_reg <= GRANT0;
                        grant_reg <= 2'b01;
                    end else if (req[1]) begin
                        state_reg <= GRANT1;
                        grant_reg <= 2'b10;
                    end
                end
                GRANT0: begin
                    if (!req[0]) begin
                        // Master abandoned its request: release without
                        // counting it as a completed transfer.
                        state_reg <= IDLE;
                        grant_reg <= 2'b00;
                    end else if (!waitrequest) begin
                        last_owner_reg <= 1'b0;
                        if (req[1]) begin
                            state_reg <= GRANT1;
                            grant_reg <= 2'b10;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= 2'b00;
                        end
                    end
                end
                GRANT1: begin
                    if (!req[1]) begin
                        state_reg <= IDLE;
                        grant_reg <= 2'b00;
                    end else if (!waitrequest) begin
                        last_owner_reg <= 1'b1;
                        if (req[0]) begin
                            state_reg <= GRANT0;
                            grant_reg <= 2'b01;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side mux: forward the owner's signals, write wins over read,
    // and drive everything to zero when nobody owns the bus.
    always_comb begin
        address    = 32'd0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        read       = 1'b0;
        write      = 1'b0;
        if (busy) begin
            address    = sel ? m1_address    : m0_address;
            writedata  = sel ? m1_writedata  : m0_writedata;
            byteenable = sel ? m1_byteenable : m0_byteenable;
            write      = port_write[sel];
            read       = port_read[sel] & ~port_write[sel];
        end
    end

endmodule
